intr_ctrl: RTL
==============

# intr_ctrl

Interrupt controller directly upstream of the exception-vector priority encoder. Synchronizes four external interrupt lines, latches rising edges as sticky pending bits, applies a per-source enable mask and a global enable, and runs a request/acknowledge/return handshake with the CPU. It drives a registered one-hot `done[3:0]` that the encoder turns into the vector address, and it blocks nesting until the handler executes `eret`.

## Interface
- `N_SRC`, default 4: number of sources. Fixed at 4 to match the encoder's `done` width.
- `clk`  in  1  system clock. All state updates on posedge.
- `rst`  in  1  synchronous reset, active-low.
- `irq_in`  in  4  raw interrupt lines, asynchronous to `clk`, level-high.
- `int_en`  in  1  global interrupt enable from the CPU status register.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  4  new mask value; bit i = 1 enables source i.
- `pend_clr`  in  4  software clear of pending bits; one-cycle strobes.
- `irq_ack`  in  1  CPU has taken the vector; one-cycle pulse.
- `eret`  in  1  handler return; one-cycle pulse.
- `irq_req`  out  1  interrupt request to the CPU.
- `done`  out  4  one-hot selected source to the encoder; 0 when idle.
- `pending`  out  4  latched pending bits, for status readback.
- `mask`  out  4  current mask.
- `in_service`  out  4  one-hot source currently being serviced.

## Operation
- **Reset** (`rst` = 0 at posedge): all outputs 0, synchronizer flops 0, state IDLE.
- **Input capture:** per source, a 2-flop synchronizer feeds a third flop. `rise[i] = s2 & ~s3`. Rising edges only; a held level produces one event.
- **Pending update:** `pending_next = (pending & ~clr) | rise`.
  - `clr` is the OR of `pend_clr` and the ack clear of the winner.
  - When `rise` and a clear hit the same bit together, the set wins, so no event is lost.
- **Masking:** the mask gates arbitration only. Masked sources still latch pending.
- **Arbitration:** `eligible = pending & mask`. The winner is the lowest index, so source 0 has highest priority.
- **FSM states:** IDLE, REQ, SERV.
  - **IDLE:** if `int_en` and `|eligible`, then `done <= onehot(winner)`, `irq_req <= 1`, go to REQ.
  - **REQ:** `done` and `irq_req` are held stable. There is no re-arbitration, even if a higher-priority source arrives.
    - On `irq_ack`: clear `pending[winner]`, `in_service <= done`, `done <= 0`, `irq_req <= 0`, go to SERV.
    - Withdrawal: if `int_en` = 0, or the winner's mask bit is 0, or the winner's pending bit is cleared by `pend_clr` (all without ack), then `done <= 0`, `irq_req <= 0`, go to IDLE. Pending is kept unless `pend_clr` cleared it.
    - Ack takes precedence over withdrawal in the same cycle.
  - **SERV:** no new requests. On `eret`: `in_service <= 0`, go to IDLE.
- **Ignored inputs:**
  - `irq_ack` outside REQ.
  - `eret` outside SERV.
- **Mask write:** `mask_we` loads `mask_wdata` at the posedge.

## Timing
- `irq_in` high before edge E0 gives `pending` set at E2. If eligible and the FSM is IDLE, `irq_req`/`done` are visible after E3.
- `done` changes only on posedge. It is stable at the following negedge, where the encoder samples it.
- Ack at edge A: `irq_req` = 0 and `done` = 0 after A, state SERV.
- `eret` at edge R: IDLE after R. The earliest new `irq_req` is after R+1.
- `mask` and `pend_clr` changes affect arbitration from the next edge.
- Reset mid-operation: REQ and SERV are abandoned, all pending events are lost, and `done` = 0 after the reset edge.

## Structure
- **Package `intr_pkg`:** `N_SRC`, FSM state enum (IDLE/REQ/SERV), and a lowest-index one-hot priority function.
- **Sub-module `intr_sync_edge`:** 3-flop synchronizer plus rise detect. Instantiated once per source (4×). The top level holds pending, mask, FSM and outputs.

## Test plan
- **Single source:** pulse `irq_in`=4'b0100 with `mask`=4'hF and `int_en`=1 → `pending`=4'b0100, then `irq_req`=1 and `done`=4'b0100. Ack → `in_service`=4'b0100, `pending`=0. `eret` → `in_service`=0.
- **Priority:** `irq_in` rises 4'b1010 in the same cycle → `done`=4'b0010. After ack and `eret` → `done`=4'b1000 with no new edge.
- **Mask and withdrawal:**
  - `mask`=4'b1110 with source 0 rising → `pending`=4'b0001, `irq_req` stays 0.
  - Write `mask`=4'hF → request for source 0.
  - Drop `int_en` in REQ → `irq_req`=0, `done`=0, `pending` still 4'b0001.
- **No nesting / no preemption:**
  - Source 3 in SERV, source 0 rises → `irq_req` stays 0 until `eret`, then `done`=4'b0001.
  - Source 0 arriving during REQ for source 2 leaves `done`=4'b0100.
- **Set/clear collision:** a new rise on source 1 in the same cycle as its ack clear → `pending[1]`=1 after the edge.
- **Reset in REQ:** `rst`=0 → `irq_req`, `done`, `pending`, `mask`, `in_service` all 0 next edge. `irq_ack` after reset is ignored.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: source count, FSM
// encoding and the fixed-priority selection helper.
package intr_pkg;

  localparam int N_SRC = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  // One-hot of the lowest set bit; source 0 has the highest priority.
  function automatic logic [N_SRC-1:0] lowest_onehot(input logic [N_SRC-1:0] v);
    logic [N_SRC-1:0] r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Signal bundle between the CPU side (master) and the interrupt
// controller (slave).
interface intr_ctrl_if;
  import intr_pkg::*;

  logic [N_SRC-1:0] irq_in;
  logic             int_en;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic [N_SRC-1:0] pend_clr;
  logic             irq_ack;
  logic             eret;
  logic             irq_req;
  logic [N_SRC-1:0] done;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] in_service;

  modport slave (
    input  irq_in, int_en, mask_we, mask_wdata, pend_clr, irq_ack, eret,
    output irq_req, done, pending, mask, in_service
  );

  modport master (
    output irq_in, int_en, mask_we, mask_wdata, pend_clr, irq_ack, eret,
    input  irq_req, done, pending, mask, in_service
  );

endinterface

// File: rtl/intr_sync_edge.sv
// Brings one asynchronous interrupt line into the clk domain and flags
// its rising edge for exactly one cycle.
module intr_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  // Two metastability flops followed by a history flop for edge detect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: sticky pending bits, mask, fixed priority and a
// request/ack/eret handshake that forbids nesting. done is registered so
// the downstream encoder can sample it on the negedge.
module intr_ctrl
  import intr_pkg::*;
(
  input logic       clk,
  input logic       rst,
  intr_ctrl_if.slave bus
);

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending_r, mask_r, done_r, in_service_r;
  logic [N_SRC-1:0] done_n, in_service_n, ack_clr;
  logic [N_SRC-1:0] eligible, winner;
  logic             irq_req_r, irq_req_n;
  state_t           state, state_n;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    intr_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.irq_in[g]),
      .rise     (rise[g])
    );
  end

  assign eligible = pending_r & mask_r;
  assign winner   = lowest_onehot(eligible);

  // Next-state and next-output decode; REQ holds its choice, ack beats withdrawal.
  always_comb begin
    state_n      = state;
    done_n       = done_r;
    irq_req_n    = irq_req_r;
    in_service_n = in_service_r;
    ack_clr      = '0;
    unique case (state)
      IDLE: begin
        if (bus.int_en && (|eligible)) begin
          done_n    = winner;
          irq_req_n = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          ack_clr      = done_r;
          in_service_n = done_r;
          done_n       = '0;
          irq_req_n    = 1'b0;
          state_n      = SERV;
        end else if (!bus.int_en || !(|(done_r & mask_r)) ||
                     (|(done_r & bus.pend_clr))) begin
          done_n    = '0;
          irq_req_n = 1'b0;
          state_n   = IDLE;
        end
      end
      SERV: begin
        if (bus.eret) begin
          in_service_n = '0;
          state_n      = IDLE;
        end
      end
      default: begin
        done_n       = '0;
        irq_req_n    = 1'b0;
        in_service_n = '0;
        state_n      = IDLE;
      end
    endcase
  end

  // FSM state and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      done_r       <= '0;
      irq_req_r    <= 1'b0;
      in_service_r <= '0;
    end else begin
      state        <= state_n;
      done_r       <= done_n;
      irq_req_r    <= irq_req_n;
      in_service_r <= in_service_n;
    end
  end

  // Sticky pending (a new edge wins over any clear) and the mask register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_r <= '0;
      mask_r    <= '0;
    end else begin
      pending_r <= (pending_r & ~(bus.pend_clr | ack_clr)) | rise;
      if (bus.mask_we) begin
        mask_r <= bus.mask_wdata;
      end
    end
  end

  assign bus.irq_req    = irq_req_r;
  assign bus.done       = done_r;
  assign bus.pending    = pending_r;
  assign bus.mask       = mask_r;
  assign bus.in_service = in_service_r;

endmodule
